// File: rtl/bpu_resolve_sched.sv
// bpu_resolve_sched: resolves branches, sequences flush/recovery on mispredict, and queues predictor updates
module bpu_resolve_sched #(
  parameter int DEPTH = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             upd_taken,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             fetch_stall,
  output logic [CNT_W-1:0] mispredict_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;
  state_t state;
  logic [3:0] rec_cnt;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, enq, deq, mis;
  logic [31:0] corr;
  always_comb begin
    full = count == CW'(DEPTH);
    res_ready = (state == IDLE) && !full;
    enq = res_valid && res_ready;
    upd_valid = count != '0;
    deq = upd_valid && upd_ready;
    mis = (res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target);
    corr = res_taken ? res_target : res_pc + 32'd4;
    upd_pc = pc_mem[rd_ptr];
    upd_target = tgt_mem[rd_ptr];
    upd_taken = taken_mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr] <= res_pc;
      tgt_mem[wr_ptr] <= res_target;
      taken_mem[wr_ptr] <= res_taken;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end
  // RECOVER exits the cycle after rec_cnt reads zero, giving FLUSH_CYCLES recovery cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flush <= 1'b0;
      fetch_stall <= 1'b0;
      redirect_pc <= '0;
      rec_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (enq && mis && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      case (state)
        IDLE: if (enq && mis) begin
          state <= FLUSH;
          flush <= 1'b1;
          fetch_stall <= 1'b1;
          redirect_pc <= corr;
        end
        FLUSH: begin
          flush <= 1'b0;
          rec_cnt <= 4'(FLUSH_CYCLES - 1);
          state <= (FLUSH_CYCLES > 0) ? RECOVER : IDLE;
          fetch_stall <= FLUSH_CYCLES > 0;
        end
        RECOVER: begin
          rec_cnt <= rec_cnt - 4'd1;
          if (rec_cnt == '0) begin
            state <= IDLE;
            fetch_stall <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
